// File: rtl/rdback_collector.sv
// rdback_collector: counts issued DDR reads and buffers returned read-data beats in a FWFT FIFO
// with sticky errors for unexpected beats and beats dropped on a full buffer.
module rdback_collector #(
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 16,
   parameter int PEND_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [3:0]                 ddr_read,
   input  logic                       ddr_rdata_valid,
   input  logic [DATA_WIDTH-1:0]      ddr_rdata,
   output logic                       rb_valid,
   output logic [DATA_WIDTH-1:0]      rb_data,
   input  logic                       rb_ready,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic [PEND_WIDTH-1:0]      pending,
   output logic                       err_unexpected,
   output logic                       err_overflow,
   input  logic                       clear_err
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr, rd_ptr;
   logic [2:0]            inc;
   logic [PEND_WIDTH:0]   sum, diff;
   logic                  dec, unexp, full, empty, pop, push, drop;
   always_comb begin
      inc   = {2'b0, ddr_read[0]} + {2'b0, ddr_read[1]} + {2'b0, ddr_read[2]} + {2'b0, ddr_read[3]};
      sum   = {1'b0, pending} + {{(PEND_WIDTH-2){1'b0}}, inc};
      dec   = ddr_rdata_valid & (sum != '0);
      unexp = ddr_rdata_valid & (sum == '0);
      diff  = sum - {{PEND_WIDTH{1'b0}}, dec};
      empty = wr_ptr == rd_ptr;
      full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      pop   = !empty & rb_ready;
      push  = dec & (!full | pop);
      drop  = dec & full & !pop;
   end
   assign rb_valid   = !empty;
   assign rb_data    = mem[rd_ptr[AW-1:0]];
   assign fifo_count = wr_ptr - rd_ptr;
   always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= ddr_rdata;
   // overshoot into the extra top bit of diff means the counter would pass its maximum
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         pending        <= '0;
         err_unexpected <= 1'b0;
         err_overflow   <= 1'b0;
      end else begin
         wr_ptr         <= wr_ptr + {{AW{1'b0}}, push};
         rd_ptr         <= rd_ptr + {{AW{1'b0}}, pop};
         pending        <= diff[PEND_WIDTH] ? {PEND_WIDTH{1'b1}} : diff[PEND_WIDTH-1:0];
         err_unexpected <= unexp | (err_unexpected & !clear_err);
         err_overflow   <= drop | (err_overflow & !clear_err);
      end
endmodule
